// File: rtl/mem_access_ctrl_if.sv
// Mem-stage and data-bus signal bundle for mem_access_ctrl.
// master = the controller, slave = the pipeline/bus side driving it.
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [1:0]            size_i;
    logic                  unsigned_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  stall_o;
    logic                  done_o;
    logic                  err_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic [3:0]            bus_be_o;
    logic [DATA_WIDTH-1:0] bus_wdata_o;
    logic                  bus_gnt_i;
    logic                  bus_rvalid_i;
    logic [DATA_WIDTH-1:0] bus_rdata_i;

    modport master (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output stall_o, done_o, err_o, rdata_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
    );

    modport slave (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  stall_o, done_o, err_o, rdata_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a single-outstanding req/gnt/rvalid data bus,
// with byte-lane steering, load extension and alignment/timeout errors.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_access_ctrl_if.master mem
);
    // state  | meaning
    // IDLE   | waiting for a load/store from the mem stage
    // REQ    | bus_req_o high, waiting for grant
    // WAIT   | load granted, waiting for read data
    // DONE   | access finished cleanly, done_o pulse
    // ERR    | misaligned/illegal/timeout, done_o + err_o pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                state;
    logic [TW-1:0]         tmo_cnt;
    logic [1:0]            lat_size;
    logic                  lat_unsigned;
    logic [1:0]            lat_off;

    logic                  misaligned;
    logic                  tmo_hit;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = mem.wdata_i;
        case (mem.size_i)
            2'b00: begin
                be_next    = 4'b0001 << mem.addr_i[1:0];
                wdata_next = {4{mem.wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = mem.addr_i[0];
                be_next    = mem.addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{mem.wdata_i[15:0]}};
            end
            2'b10: misaligned = (mem.addr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Load data is extracted from the lane picked by the latched byte offset.
    always_comb begin
        shifted  = mem.bus_rdata_i >> {lat_off, 3'b000};
        load_ext = shifted;
        case (lat_size)
            2'b00:   load_ext = {{(DATA_WIDTH-8){~lat_unsigned & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{(DATA_WIDTH-16){~lat_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    // Reset gates stall so every output reads 0 while rst_i is high.
    always_comb begin
        mem.stall_o = ~rst_i & (((state == S_IDLE) & mem.req_i) |
                                (state == S_REQ) | (state == S_WAIT));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            tmo_cnt         <= '0;
            lat_size        <= 2'b00;
            lat_unsigned    <= 1'b0;
            lat_off         <= 2'b00;
            mem.done_o      <= 1'b0;
            mem.err_o       <= 1'b0;
            mem.rdata_o     <= '0;
            mem.bus_req_o   <= 1'b0;
            mem.bus_we_o    <= 1'b0;
            mem.bus_addr_o  <= '0;
            mem.bus_be_o    <= 4'b0000;
            mem.bus_wdata_o <= '0;
        end else begin
            mem.done_o <= 1'b0;
            mem.err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem.req_i) begin
                        if (misaligned) begin
                            state      <= S_ERR;
                            mem.done_o <= 1'b1;
                            mem.err_o  <= 1'b1;
                        end else begin
                            state           <= S_REQ;
                            tmo_cnt         <= '0;
                            lat_size        <= mem.size_i;
                            lat_unsigned    <= mem.unsigned_i;
                            lat_off         <= mem.addr_i[1:0];
                            mem.bus_req_o   <= 1'b1;
                            mem.bus_we_o    <= mem.we_i;
                            mem.bus_addr_o  <= {mem.addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem.bus_be_o    <= be_next;
                            mem.bus_wdata_o <= wdata_next;
                        end
                    end
                end
                S_REQ: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (mem.bus_gnt_i) begin
                        mem.bus_req_o <= 1'b0;
                        if (mem.bus_we_o) begin
                            state      <= S_DONE;
                            mem.done_o <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else if (tmo_hit) begin
                        state         <= S_ERR;
                        mem.bus_req_o <= 1'b0;
                        mem.done_o    <= 1'b1;
                        mem.err_o     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (mem.bus_rvalid_i) begin
                        state       <= S_DONE;
                        mem.rdata_o <= load_ext;
                        mem.done_o  <= 1'b1;
                    end else if (tmo_hit) begin
                        state      <= S_ERR;
                        mem.done_o <= 1'b1;
                        mem.err_o  <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=8) with hand-computed expectations.
module tb_mem_access_ctrl;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mem_access_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

    mem_access_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .mem  (mif)
    );

    // {stall_o, done_o, err_o, bus_req_o}
    logic [3:0] flags;
    assign flags = {mif.stall_o, mif.done_o, mif.err_o, mif.bus_req_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mif.req_i        = 1'b0;
        mif.we_i         = 1'b0;
        mif.size_i       = 2'b00;
        mif.unsigned_i   = 1'b0;
        mif.addr_i       = '0;
        mif.wdata_i      = '0;
        mif.bus_gnt_i    = 1'b0;
        mif.bus_rvalid_i = 1'b0;
        mif.bus_rdata_i  = '0;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        mif.req_i      = 1'b1;
        mif.we_i       = we;
        mif.size_i     = size;
        mif.unsigned_i = uns;
        mif.addr_i     = addr;
        mif.wdata_i    = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        mif.req_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0000", flags);
        end
        n_vec++;
        if ({mif.rdata_o, mif.bus_addr_o, mif.bus_wdata_o, mif.bus_be_o, mif.bus_we_o} !== '0) begin
            n_err++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h be %b we %b expected all 0",
                     mif.rdata_o, mif.bus_addr_o, mif.bus_wdata_o, mif.bus_be_o, mif.bus_we_o);
        end
        drive_idle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        // Store in flight, then reset while in REQ.
        drive_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b1000) begin
            n_err++;
            $display("FAIL rst_mid_c0: got %b expected 1000", flags);
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b1001) begin
            n_err++;
            $display("FAIL rst_mid_req: got %b expected 1001", flags);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid_drop: got %b expected 0000", flags);
        end
        drive_idle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (flags !== 4'b0000) begin
                n_err++;
                $display("FAIL rst_after_%0d: got %b expected 0000", i, flags);
            end
            next_cycle();
        end
    endtask

    task automatic test_sb();
        drive_req(1'b1, 2'b00, 1'b0, 32'h1003, 32'h000000A5);
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b1000) begin
            n_err++;
            $display("FAIL sb_c0: got %b expected 1000", flags);
        end
        next_cycle();
        mif.bus_gnt_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b1001) begin
            n_err++;
            $display("FAIL sb_c1_flags: got %b expected 1001", flags);
        end
        n_vec++;
        if ({mif.bus_we_o, mif.bus_be_o, mif.bus_addr_o, mif.bus_wdata_o} !==
            {1'b1, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5}) begin
            n_err++;
            $display("FAIL sb_c1_bus: we %b be %b addr %h wdata %h expected 1 1000 00001000 a5a5a5a5",
                     mif.bus_we_o, mif.bus_be_o, mif.bus_addr_o, mif.bus_wdata_o);
        end
        next_cycle();
        mif.bus_gnt_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0100) begin
            n_err++;
            $display("FAIL sb_c2_done: got %b expected 0100", flags);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL sb_c3_idle: got %b expected 0000", flags);
        end
        next_cycle();
    endtask

    task automatic test_lh(input logic uns, input logic [31:0] exp_rdata);
        drive_req(1'b0, 2'b01, uns, 32'h2002, 32'h0);
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b1000) begin
            n_err++;
            $display("FAIL lh%0d_c0: got %b expected 1000", uns, flags);
        end
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            mif.bus_gnt_i = (c == 4);
            @(negedge clk);
            n_vec++;
            if ({flags, mif.bus_we_o, mif.bus_be_o, mif.bus_addr_o} !==
                {4'b1001, 1'b0, 4'b1100, 32'h0000_2000}) begin
                n_err++;
                $display("FAIL lh%0d_req_c%0d: flags %b we %b be %b addr %h expected 1001 0 1100 00002000",
                         uns, c, flags, mif.bus_we_o, mif.bus_be_o, mif.bus_addr_o);
            end
            next_cycle();
        end
        mif.bus_gnt_i    = 1'b0;
        mif.bus_rvalid_i = 1'b1;
        mif.bus_rdata_i  = 32'h8001_1234;
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b1000) begin
            n_err++;
            $display("FAIL lh%0d_wait: got %b expected 1000", uns, flags);
        end
        next_cycle();
        mif.bus_rvalid_i = 1'b0;
        mif.bus_rdata_i  = 32'h0;
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0100) begin
            n_err++;
            $display("FAIL lh%0d_done: got %b expected 0100", uns, flags);
        end
        n_vec++;
        if (mif.rdata_o !== exp_rdata) begin
            n_err++;
            $display("FAIL lh%0d_rdata: got %h expected %h", uns, mif.rdata_o, exp_rdata);
        end
        next_cycle();
        drive_idle();
        next_cycle();
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        sizes[0] = 2'b10; addrs[0] = 32'h3001;
        sizes[1] = 2'b01; addrs[1] = 32'h0011;
        sizes[2] = 2'b11; addrs[2] = 32'h0020;
        for (int k = 0; k < 3; k++) begin
            drive_req(1'b0, sizes[k], 1'b0, addrs[k], 32'h0);
            mif.bus_gnt_i = 1'b1;
            @(negedge clk);
            n_vec++;
            if (flags !== 4'b1000) begin
                n_err++;
                $display("FAIL mis%0d_c0: got %b expected 1000", k, flags);
            end
            next_cycle();
            @(negedge clk);
            n_vec++;
            if (flags !== 4'b0110) begin
                n_err++;
                $display("FAIL mis%0d_err: got %b expected 0110", k, flags);
            end
            n_vec++;
            if (mif.rdata_o !== 32'h0000_8001) begin
                n_err++;
                $display("FAIL mis%0d_rdata_hold: got %h expected 00008001", k, mif.rdata_o);
            end
            next_cycle();
            drive_idle();
            @(negedge clk);
            n_vec++;
            if (flags !== 4'b0000) begin
                n_err++;
                $display("FAIL mis%0d_after: got %b expected 0000", k, flags);
            end
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        drive_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        next_cycle();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            n_vec++;
            if (flags !== 4'b1001) begin
                n_err++;
                $display("FAIL tmo_req_c%0d: got %b expected 1001", c, flags);
            end
            next_cycle();
        end
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0110) begin
            n_err++;
            $display("FAIL tmo_err: got %b expected 0110", flags);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL tmo_after: got %b expected 0000", flags);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        drive_req(1'b0, 2'b00, 1'b0, 32'h5001, 32'h0);
        next_cycle();
        mif.bus_gnt_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({flags, mif.bus_be_o, mif.bus_addr_o} !== {4'b1001, 4'b0010, 32'h0000_5000}) begin
            n_err++;
            $display("FAIL b2b_lb_req: flags %b be %b addr %h expected 1001 0010 00005000",
                     flags, mif.bus_be_o, mif.bus_addr_o);
        end
        next_cycle();
        mif.bus_gnt_i    = 1'b0;
        mif.bus_rvalid_i = 1'b1;
        mif.bus_rdata_i  = 32'h0000_F000;
        next_cycle();
        mif.bus_rvalid_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0100 || mif.rdata_o !== 32'hFFFF_FFF0) begin
            n_err++;
            $display("FAIL b2b_lb_done: flags %b rdata %h expected 0100 fffffff0", flags, mif.rdata_o);
        end
        next_cycle();
        drive_req(1'b1, 2'b10, 1'b0, 32'h6000, 32'h1234_5678);
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b1000) begin
            n_err++;
            $display("FAIL b2b_gap_idle: got %b expected 1000", flags);
        end
        next_cycle();
        mif.bus_gnt_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({flags, mif.bus_we_o, mif.bus_be_o, mif.bus_addr_o, mif.bus_wdata_o} !==
            {4'b1001, 1'b1, 4'b1111, 32'h0000_6000, 32'h1234_5678}) begin
            n_err++;
            $display("FAIL b2b_sw_req: flags %b we %b be %b addr %h wdata %h expected 1001 1 1111 00006000 12345678",
                     flags, mif.bus_we_o, mif.bus_be_o, mif.bus_addr_o, mif.bus_wdata_o);
        end
        next_cycle();
        mif.bus_gnt_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0100 || mif.rdata_o !== 32'hFFFF_FFF0) begin
            n_err++;
            $display("FAIL b2b_sw_done: flags %b rdata %h expected 0100 fffffff0", flags, mif.rdata_o);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL b2b_after: got %b expected 0000", flags);
        end
        next_cycle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_sb();
        test_lh(1'b0, 32'hFFFF_8001);
        test_lh(1'b1, 32'h0000_8001);
        test_misaligned();
        test_timeout();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory load/store accesses issued by the mem stage onto a single-outstanding request/grant/response data bus.
- Drives stall_o to hold the pipeline while an access is in flight.
- Generates byte enables and write-data lane replication, and sign/zero-extends load data.
- Reports misaligned accesses and bus timeouts as errors.

Parameters:
ADDR_WIDTH, 32, width of addr_i and bus_addr_o
DATA_WIDTH, 32, data width (fixed 4 byte lanes)
TIMEOUT, 255, max cycles spent in REQ+WAIT before an access is aborted with an error

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
req_i  input  1  mem stage holds a load/store this cycle
we_i  input  1  1=store, 0=load
size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
unsigned_i  input  1  zero-extend load (LBU/LHU)
addr_i  input  ADDR_WIDTH  byte address
wdata_i  input  DATA_WIDTH  store data, low-aligned
stall_o  output  1  hold pipeline
done_o  output  1  one-cycle pulse: access finished (ok or error)
err_o  output  1  one-cycle pulse with done_o: misaligned, illegal size or timeout
rdata_o  output  DATA_WIDTH  extended load result, registered
bus_req_o  output  1  bus request
bus_we_o  output  1  bus write
bus_addr_o  output  ADDR_WIDTH  word-aligned address (addr_i[1:0] forced 0)
bus_be_o  output  4  byte enables
bus_wdata_o  output  DATA_WIDTH  lane-replicated store data
bus_gnt_i  input  1  bus accepts request this cycle
bus_rvalid_i  input  1  read data valid
bus_rdata_i  input  DATA_WIDTH  read data

Behaviour:
- Reset, asynchronous, active-high:
  - state IDLE, timeout counter 0.
  - All outputs 0; rdata_o = 0.
  - Reset mid-access drops bus_req_o immediately; no done_o.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE, req_i=1:
  - Misaligned → ERR. Misaligned means size 11, half with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise latch we, size, unsigned, addr, be and wdata → REQ.
- REQ:
  - bus_req_o=1; bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o are driven from the latched values and held stable until grant.
  - bus_gnt_i=1: store → DONE; load → WAIT.
- WAIT:
  - bus_req_o=0.
  - bus_rvalid_i=1 → capture the extracted bus_rdata_i into rdata_o, then → DONE.
  - rvalid arriving in the same cycle as gnt is not supported; the bus guarantees rvalid no earlier than the cycle after gnt.
- DONE: done_o=1 → IDLE. req_i is ignored in this cycle (same instruction still present).
- ERR: done_o=1, err_o=1, no bus activity, rdata_o unchanged → IDLE.
- Timeout:
  - The counter clears on IDLE→REQ and increments each cycle in REQ/WAIT.
  - When the count reaches TIMEOUT-1 without gnt (REQ) or rvalid (WAIT) → ERR. bus_req_o deasserts the same edge.
- stall_o (combinational) = (IDLE & req_i) | REQ | WAIT. It is 0 in DONE and ERR, so the pipeline advances exactly once per access.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << (2*addr[1])
  - word: 1111
- Store data:
  - byte → {4{wdata[7:0]}}
  - half → {2{wdata[15:0]}}
  - word → wdata
- Load extract:
  - Shift bus_rdata_i right by 8*addr[1:0].
  - Take 8/16/32 bits; sign-extend unless unsigned_i.
- Latency from req_i in IDLE (cycle 0), with gnt immediate:
  - store: done_o at cycle 2.
  - load with rvalid at cycle 2: rdata_o valid and done_o at cycle 3.
- rdata_o holds its value until the next load completes.

Test Plan:
- Reset: assert rst_i mid-REQ → bus_req_o=0, stall_o=0 and state IDLE in the same cycle; done_o never pulses.
- SB addr=0x1003, wdata=0x000000A5, gnt immediate → bus_be_o=1000, bus_wdata_o=0xA5A5A5A5, bus_addr_o=0x1000, done_o at cycle 2, stall_o 1 in cycles 0–1.
- LH addr=0x2002, bus_rdata_i=0x8001_1234, gnt after 3 cycles, rvalid the next cycle → rdata_o=0xFFFF8001. The same access with LHU → 0x00008001.
- LW addr=0x3001 → ERR next cycle: err_o=1, done_o=1, bus_req_o never asserted, stall_o 1 for one cycle only.
- Load with gnt never asserted, TIMEOUT=8 → err_o and done_o pulse after 8 cycles, bus_req_o drops, stall_o released.
- Back-to-back: LB then SW with req_i held across DONE → two distinct bus requests with exactly one IDLE cycle between them; no duplicate access in DONE.
